// File: rtl/vga_fb_sched_if.sv
// Shared frame-buffer port bundle: engine request side plus the BRAM port it is muxed onto.
// The scheduler takes the slave modport; the engine/BRAM side takes the master modport.
interface vga_fb_sched_if #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 12
);
  logic          eng_req;
  logic          eng_we;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_wdata;
  logic          eng_gnt;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_wdata;

  modport master (
    output eng_req, eng_we, eng_addr, eng_wdata,
    input  eng_gnt, bram_addr, bram_we, bram_wdata
  );

  modport slave (
    input  eng_req, eng_we, eng_addr, eng_wdata,
    output eng_gnt, bram_addr, bram_we, bram_wdata
  );
endinterface

// File: rtl/vga_fb_sched.sv
// Frame-buffer port scheduler: holds VGA timing off until a frame is loaded, then walks the
// display window addresses and gives the single BRAM port to the engine on idle display cycles.
module vga_fb_sched #(
  parameter int unsigned IMG_W = 400,
  parameter int unsigned IMG_H = 300,
  parameter int unsigned AW    = 17,
  parameter int unsigned DW    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 fill_done,
  input  logic                 vsync,
  input  logic                 valid_down,
  output logic                 all_ready,
  output logic                 frame_done,
  output logic                 sync_err,
  vga_fb_sched_if.slave        bus
);

  localparam logic [AW-1:0] LastAddr = AW'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] disp_q, disp_d;
  logic          all_ready_q, all_ready_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_err_q, sync_err_d;
  logic          vsync_d_q;
  logic          vsync_fall;
  logic          disp_cycle;

  assign vsync_fall = vsync_d_q & ~vsync;

  always_comb begin
    state_d      = state_q;
    disp_d       = disp_q;
    sync_err_d   = sync_err_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        sync_err_d = 1'b0;
        if (enable) state_d = StFill;
      end
      StFill: begin
        // Dropping enable wins over a coincident fill_done.
        if (!enable) begin
          state_d = StIdle;
        end else if (fill_done) begin
          state_d = StRun;
          disp_d  = '0;
        end
      end
      StRun: begin
        if (!enable) state_d = StIdle;
        // A frame start resynchronises the counter and drops any coincident increment.
        if (vsync_fall) begin
          disp_d = '0;
          if (disp_q != '0) sync_err_d = 1'b1;
        end else if (valid_down) begin
          if (disp_q == LastAddr) begin
            disp_d       = '0;
            frame_done_d = 1'b1;
          end else begin
            disp_d = disp_q + AW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    all_ready_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      disp_q       <= '0;
      all_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      vsync_d_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      disp_q       <= disp_d;
      all_ready_q  <= all_ready_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      vsync_d_q    <= vsync;
    end
  end

  // Display reads always win the port; the engine only sees the leftover cycles.
  assign disp_cycle = (state_q == StRun) && valid_down;

  always_comb begin
    bus.eng_gnt    = bus.eng_req & ~disp_cycle;
    bus.bram_wdata = bus.eng_wdata;
    if (disp_cycle) begin
      bus.bram_addr = disp_q;
      bus.bram_we   = 1'b0;
    end else begin
      bus.bram_addr = bus.eng_addr;
      bus.bram_we   = bus.eng_we & bus.eng_gnt;
    end
  end

  assign all_ready  = all_ready_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_vga_fb_sched.sv
// Directed bench for vga_fb_sched on a reduced 40x30 window so a full frame fits in a short run.
module tb_vga_fb_sched;

  localparam int unsigned IMG_W = 40;
  localparam int unsigned IMG_H = 30;
  localparam int unsigned AW    = 17;
  localparam int unsigned DW    = 12;
  localparam int unsigned NPIX  = IMG_W * IMG_H;

  logic clk;
  logic rst_n;
  logic enable;
  logic fill_done;
  logic vsync;
  logic valid_down;
  logic all_ready;
  logic frame_done;
  logic sync_err;

  vga_fb_sched_if #(.AW(AW), .DW(DW)) bus ();

  vga_fb_sched #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fill_done (fill_done),
    .vsync     (vsync),
    .valid_down(valid_down),
    .all_ready (all_ready),
    .frame_done(frame_done),
    .sync_err  (sync_err),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          vd;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          e_gnt;
    logic          e_we;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eng(input logic req, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    bus.eng_req   = req;
    bus.eng_we    = we;
    bus.eng_addr  = a;
    bus.eng_wdata = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 17'd7,  12'h0a1, 1'b0, 1'b0, 17'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 17'd7,  12'h0a1, 1'b1, 1'b1, 17'd7};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 17'd9,  12'h0b2, 1'b0, 1'b0, 17'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 17'd9,  12'h0b2, 1'b1, 1'b0, 17'd9};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 17'd3,  12'h0c3, 1'b0, 1'b0, 17'd3};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 17'd3,  12'h0c3, 1'b0, 1'b0, 17'd2};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 17'd11, 12'h0d4, 1'b0, 1'b0, 17'd3};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 17'd12, 12'h0e5, 1'b1, 1'b1, 17'd12};

    rst_n      = 1'b0;
    enable     = 1'b0;
    fill_done  = 1'b0;
    vsync      = 1'b1;
    valid_down = 1'b0;
    eng(1'b0, 1'b0, '0, '0);
    #3;
    check("rst_all_ready", 32'(all_ready), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // IDLE: valid_down must not steal the port.
    valid_down = 1'b1;
    eng(1'b1, 1'b1, 17'd33, 12'h123);
    #1;
    check("idle_gnt", 32'(bus.eng_gnt), 32'd1);
    check("idle_addr", 32'(bus.bram_addr), 32'd33);

    // FILL for 100 cycles with display inputs wiggling; nothing may move.
    tick();
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      vsync      = (i % 7) != 0;
      valid_down = i[0];
      if (all_ready !== 1'b0) check("fill_all_ready", 32'(all_ready), 32'd0);
    end
    checks++;
    vsync      = 1'b1;
    valid_down = 1'b1;
    eng(1'b1, 1'b1, 17'd5, 12'h5a5);
    #1;
    check("fill_gnt", 32'(bus.eng_gnt), 32'd1);
    check("fill_bram_we", 32'(bus.bram_we), 32'd1);
    check("fill_bram_addr", 32'(bus.bram_addr), 32'd5);
    check("fill_bram_wdata", 32'(bus.bram_wdata), 32'h5a5);
    check("fill_sync_err", 32'(sync_err), 32'd0);

    // fill_done -> all_ready exactly one cycle later.
    tick();
    valid_down = 1'b0;
    fill_done  = 1'b1;
    #1;
    check("pre_run_all_ready", 32'(all_ready), 32'd0);
    tick();
    fill_done = 1'b0;
    check("run_all_ready", 32'(all_ready), 32'd1);

    // Arbitration table; display address starts at 0 and advances on vd cycles.
    for (int i = 0; i < 8; i++) begin
      valid_down = vecs[i].vd;
      eng(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_gnt", i), 32'(bus.eng_gnt), 32'(vecs[i].e_gnt));
      check($sformatf("vec%0d_we", i), 32'(bus.bram_we), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_addr", i), 32'(bus.bram_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_wdata", i), 32'(bus.bram_wdata), 32'(vecs[i].wdata));
      tick();
    end

    // Walk to the end of the frame with the engine hammering writes.
    eng(1'b1, 1'b1, 17'd99, 12'hfff);
    valid_down = 1'b1;
    for (int i = 4; i < int'(NPIX); i++) begin
      #1;
      if (bus.bram_addr !== AW'(i)) check("walk_addr", 32'(bus.bram_addr), 32'(i));
      if (bus.bram_we !== 1'b0) check("walk_we", 32'(bus.bram_we), 32'd0);
      if (frame_done !== 1'b0) check("walk_frame_done", 32'(frame_done), 32'd0);
      tick();
    end
    checks++;
    // Wrapped: frame_done now, and a clean vsync edge at address 0.
    valid_down = 1'b0;
    vsync      = 1'b0;
    #1;
    check("wrap_frame_done", 32'(frame_done), 32'd1);
    check("wrap_gnt_idle_cycle", 32'(bus.eng_gnt), 32'd1);
    tick();
    vsync = 1'b1;
    valid_down = 1'b1;
    #1;
    check("wrap_pulse_end", 32'(frame_done), 32'd0);
    check("wrap_addr", 32'(bus.bram_addr), 32'd0);
    check("clean_vsync_no_err", 32'(sync_err), 32'd0);

    // 1000 display pixels, then vsync edge coinciding with valid_down.
    for (int i = 0; i < 1000; i++) tick();
    vsync = 1'b0;
    #1;
    check("pre_vsync_addr", 32'(bus.bram_addr), 32'd1000);
    tick();
    vsync = 1'b1;
    #1;
    check("vsync_addr_zero", 32'(bus.bram_addr), 32'd0);
    check("vsync_sync_err", 32'(sync_err), 32'd1);
    valid_down = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("sync_err_sticky", 32'(sync_err), 32'd1);

    // Drop enable: IDLE next cycle, sync_err clears while in IDLE.
    enable = 1'b0;
    tick();
    check("disable_all_ready", 32'(all_ready), 32'd0);
    tick();
    check("idle_sync_err_clear", 32'(sync_err), 32'd0);

    // FILL with fill_done and enable low together -> IDLE.
    enable = 1'b1;
    tick();
    enable    = 1'b0;
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    enable    = 1'b1;
    check("prio_all_ready", 32'(all_ready), 32'd0);
    tick();
    tick();
    check("prio_still_not_ready", 32'(all_ready), 32'd0);

    // Back to RUN, set sync_err, advance to 500, then asynchronous reset mid-cycle.
    fill_done = 1'b1;
    tick();
    fill_done  = 1'b0;
    valid_down = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    for (int i = 0; i < 500; i++) tick();
    eng(1'b1, 1'b0, 17'd77, 12'h0);
    #1;
    check("mid_addr", 32'(bus.bram_addr), 32'd500);
    check("mid_sync_err", 32'(sync_err), 32'd1);
    check("mid_all_ready", 32'(all_ready), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_all_ready", 32'(all_ready), 32'd0);
    check("async_sync_err", 32'(sync_err), 32'd0);
    check("async_gnt", 32'(bus.eng_gnt), 32'd1);
    check("async_addr", 32'(bus.bram_addr), 32'd77);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_fill", 32'(all_ready), 32'd0);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    check("post_rst_run", 32'(all_ready), 32'd1);
    check("post_rst_addr", 32'(bus.bram_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_sched.md
Name: vga_fb_sched

Overview:
- Sequences and shares the single-port frame-buffer BRAM between the VGA display path and the LBP processing engine.
- Holds the VGA timing generator idle (all_ready low) until a full frame has been loaded.
- Once running, generates display read addresses for the 400x300 downsampled window.
- Arbitrates the port: display always wins; the engine gets only the cycles the display does not use.

Parameters:
IMG_W, 400, displayed window width in pixels
IMG_H, 300, displayed window height in lines
AW, 17, BRAM address width (must satisfy 2^AW >= IMG_W*IMG_H)
DW, 12, pixel width, RGB444

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; low forces IDLE
fill_done  in  1  one-cycle pulse from frame writer: full frame stored
vsync  in  1  from VGA timing generator, active low
valid_down  in  1  from VGA timing generator: downsample window pixel active
all_ready  out  1  enable to VGA timing generator
eng_req  in  1  engine access request, level
eng_we  in  1  engine write strobe, qualified by eng_gnt
eng_addr  in  AW  engine address
eng_wdata  in  DW  engine write data
eng_gnt  out  1  engine access accepted this cycle (combinational)
bram_addr  out  AW  shared BRAM address
bram_we  out  1  shared BRAM write enable
bram_wdata  out  DW  shared BRAM write data
frame_done  out  1  one-cycle pulse on display address wrap
sync_err  out  1  sticky: frame started before previous frame completed

Behaviour:
- Reset (rst_n low, asynchronous) sets: state IDLE, all_ready=0, disp_addr=0, frame_done=0, sync_err=0, vsync_d=1.
- FSM states are IDLE, FILL and RUN. All transitions are registered.
- IDLE:
  - all_ready=0.
  - enable high moves to FILL next cycle.
  - sync_err is cleared while in IDLE.
- FILL:
  - all_ready=0.
  - fill_done moves to RUN next cycle; at the same time disp_addr is set to 0.
  - enable low moves to IDLE and takes priority over a simultaneous fill_done.
- RUN:
  - all_ready=1 (registered, asserted from the first RUN cycle).
  - fill_done is ignored.
  - enable low moves to IDLE next cycle; all_ready then falls, which resets the timing generator.
- Display address counter (RUN only):
  - Increments by 1 on each cycle with valid_down=1.
  - At IMG_W*IMG_H-1 with valid_down=1: wraps to 0 and frame_done pulses the next cycle.
  - Falling edge of vsync (vsync_d=1, vsync=0) forces disp_addr to 0. If disp_addr was not 0 at that edge, sync_err is set.
  - If the vsync edge and valid_down coincide, the address is forced to 0; the increment is dropped.
- Arbitration (combinational):
  - eng_gnt = eng_req AND NOT (state==RUN AND valid_down).
  - Display cycle (RUN and valid_down): bram_addr=disp_addr, bram_we=0, bram_wdata=eng_wdata (don't-care).
  - Otherwise: bram_addr=eng_addr, bram_we=eng_we AND eng_gnt, bram_wdata=eng_wdata.
  - The engine must hold req, addr and data stable until it sees gnt. There is no queueing; a denied request is simply retried.
- Latency:
  - BRAM read data is valid one cycle after bram_addr.
  - The display path consumes rdata one cycle after valid_down; the pixel-mux alignment register lives outside this block.
- Widths:
  - disp_addr is AW bits.
  - The compare constant IMG_W*IMG_H-1 is sized to AW. No overflow is possible given the AW constraint.
- In IDLE/FILL, valid_down and vsync are ignored: disp_addr holds and sync_err is not updated.

Test Plan:
- Reset, then enable=1 with no fill_done for 100 cycles -> state FILL, all_ready=0; eng_req with eng_we=1, addr=5 -> eng_gnt=1, bram_we=1, bram_addr=5.
- fill_done pulse -> all_ready=1 exactly one cycle later, disp_addr=0; 120000 valid_down cycles -> disp_addr wraps to 0, frame_done high for exactly one cycle.
- In RUN, eng_req held high with valid_down toggling 1,0,1,0 -> eng_gnt 0,1,0,1; bram_addr alternates disp_addr/eng_addr; bram_we is never 1 while valid_down=1.
- vsync falling edge after 1000 valid_down cycles (disp_addr=1000) -> disp_addr=0 next cycle, sync_err=1 and stays set; drop enable -> IDLE, sync_err clears.
- Same cycle fill_done=1 and enable=0 in FILL -> next state IDLE, all_ready stays 0.
- rst_n asserted mid-frame in RUN (disp_addr=50000) -> all outputs reset immediately without waiting for a clock edge; state IDLE.
